and_result_checker: RTL

//  In-design checker sitting directly downstream of the registered AND stage. It samples the
//  AND stage inputs A/B and output Y, and delays the expected result A&B to match the DUV

---
 rtl/and_result_checker.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/and_result_checker.sv
// Scoreboard checker for the registered AND stage: aligns A&B with Y,
// counts matches/mismatches and queues mismatch records for a consumer.
module and_result_checker #(
    parameter int WIDTH       = 1,
    parameter int DUV_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Y,
    output logic             err_valid,
    input  logic             err_ready,
    output logic [WIDTH-1:0] err_exp,
    output logic [WIDTH-1:0] err_act,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             overflow,
    output logic [1:0]       state_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int RW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        CHECK = 2'b10
    } state_t;

    state_t state, state_nx;
    logic [3:0] fill_cnt;
    logic start_take;
    logic run;

    logic [DUV_LATENCY-1:0] pipe_v;
    logic [WIDTH-1:0]       pipe_d [DUV_LATENCY];
    logic [WIDTH-1:0]       exp_d;
    logic                   cmp;
    logic                   match;

    logic [RW-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_nx, rd_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [RW-1:0]    head, head_nx, rec_in;
    logic             full, push, pop, push_ok;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = FILL;
            FILL:    if (fill_cnt == 4'(DUV_LATENCY - 1)) state_nx = CHECK;
            CHECK:   state_nx = CHECK;
            default: state_nx = IDLE;
        endcase
        if (stop) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_cnt <= '0;
        end else if (state == FILL && !stop) begin
            fill_cnt <= fill_cnt + 4'd1;
        end else begin
            fill_cnt <= '0;
        end
    end

    assign start_take = (state == IDLE) && start && !stop;
    assign run        = (state != IDLE) && !stop;
    assign state_o    = state;

    // ---------------- expected-value delay pipe ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_v <= '0;
            for (int i = 0; i < DUV_LATENCY; i++) pipe_d[i] <= '0;
        end else if (run) begin
            pipe_v[0] <= in_valid;
            pipe_d[0] <= A & B;
            for (int i = 1; i < DUV_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end else begin
            pipe_v <= '0;
            for (int i = 0; i < DUV_LATENCY; i++) pipe_d[i] <= '0;
        end
    end

    assign exp_d = pipe_d[DUV_LATENCY-1];
    assign cmp   = (state == CHECK) && pipe_v[DUV_LATENCY-1];
    assign match = (Y == exp_d);
    assign push  = cmp && !match;

    // ---------------- saturating counters ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_cnt <= '0;
            err_cnt  <= '0;
        end else if (start_take) begin
            pass_cnt <= '0;
            err_cnt  <= '0;
        end else if (cmp) begin
            if (match && pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
            if (!match && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    // ---------------- mismatch record FIFO ----------------
    assign err_valid = (cnt != '0);
    assign full      = (cnt == CW'(FIFO_DEPTH));
    assign pop       = err_valid && err_ready;
    assign push_ok   = push && (!full || pop);
    assign rec_in    = {exp_d, Y};

    always_comb begin
        wr_nx  = push_ok ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_nx  = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        cnt_nx = cnt + CW'(push_ok) - CW'(pop);
        // head register must see a record written this very cycle
        if (cnt_nx == '0) begin
            head_nx = '0;
        end else if (push_ok && rd_nx == wr_ptr) begin
            head_nx = rec_in;
        end else begin
            head_nx = mem[rd_nx];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= rec_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            head     <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_nx;
            rd_ptr <= rd_nx;
            cnt    <= cnt_nx;
            head   <= head_nx;
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    assign err_exp = head[RW-1:WIDTH];
    assign err_act = head[WIDTH-1:0];

endmodule
